// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: turns timing-generator coordinates into framebuffer reads
// and palette-expanded 4:4:4 RGB. Optional colour bars: VGA_FETCH_TEST_PATTERN_EN.
module vga_pixel_fetch #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pixel_strobe,
  input  logic              mode,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              active_in,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [7:0]        fb_data,
  input  logic              pal_we,
  input  logic [7:0]        pal_addr,
  input  logic [11:0]       pal_wdata,
`ifdef VGA_FETCH_TEST_PATTERN_EN
  input  logic              test_en,
`endif
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync,
  output logic              vsync
);

  logic [ADDR_W-1:0]   fb_addr_q;
  logic                fb_rd_q;
  logic [ADDR_W-1:0]   y_w;
  logic [ADDR_W-1:0]   x_w;
  logic [ADDR_W-1:0]   addr_d;
  logic                fb_rd_d;
  logic [RD_LATENCY-1:0] act_dly_q;
  logic [RD_LATENCY:0] hs_dly_q;
  logic [RD_LATENCY:0] vs_dly_q;
  logic [7:0]          idx_q;
  logic                act_b_q;
  logic [11:0]         pix_d;
  logic [11:0]         rgb_q;
  logic                hs_q;
  logic                vs_q;
  logic [11:0]         pal_q [256];

  assign y_w = ADDR_W'(y);
  assign x_w = ADDR_W'(x);

  // y*320 or y*640 built from two shifts, no multiplier
  assign addr_d = mode ? (y_w << 8) + (y_w << 6) + x_w
                       : (y_w << 9) + (y_w << 7) + x_w;

`ifdef VGA_FETCH_TEST_PATTERN_EN
  logic [2:0] bar_dly_q [RD_LATENCY];
  logic [2:0] bar_b_q;

  assign fb_rd_d = active_in & ~test_en;
  assign pix_d   = !act_b_q ? 12'h000 :
                   test_en  ? {{4{bar_b_q[2]}}, {4{bar_b_q[1]}},
                               {4{bar_b_q[0]}}} :
                              pal_q[idx_q];

  // bar index travels alongside the RAM read so it lines up with stage C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) bar_dly_q[i] <= 3'd0;
      bar_b_q <= 3'd0;
    end else if (pixel_strobe) begin
      bar_dly_q[0] <= x[9:7];
      for (int i = 1; i < RD_LATENCY; i++) bar_dly_q[i] <= bar_dly_q[i-1];
      bar_b_q <= bar_dly_q[RD_LATENCY-1];
    end
  end
`else
  assign fb_rd_d = active_in;
  assign pix_d   = act_b_q ? pal_q[idx_q] : 12'h000;
`endif

  // stage A: issue read, plus active/sync delay lines matching RAM latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_addr_q <= '0;
      fb_rd_q   <= 1'b0;
      act_dly_q <= '0;
      hs_dly_q  <= '1;
      vs_dly_q  <= '1;
    end else if (pixel_strobe) begin
      fb_rd_q <= fb_rd_d;
      if (active_in) fb_addr_q <= addr_d;
      act_dly_q[0] <= active_in;
      for (int i = 1; i < RD_LATENCY; i++) act_dly_q[i] <= act_dly_q[i-1];
      hs_dly_q[0] <= hsync_in;
      vs_dly_q[0] <= vsync_in;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        hs_dly_q[i] <= hs_dly_q[i-1];
        vs_dly_q[i] <= vs_dly_q[i-1];
      end
    end
  end

  // stage B: capture palette index returned by video RAM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= 8'd0;
      act_b_q <= 1'b0;
    end else if (pixel_strobe) begin
      idx_q   <= fb_data;
      act_b_q <= act_dly_q[RD_LATENCY-1];
    end
  end

  // stage C: palette expansion and aligned syncs to the DAC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pixel_strobe) begin
      rgb_q <= pix_d;
      hs_q  <= hs_dly_q[RD_LATENCY];
      vs_q  <= vs_dly_q[RD_LATENCY];
    end
  end

  // palette write port; a same-cycle lookup still sees the old entry
  always_ff @(posedge clk) begin
    if (pal_we) pal_q[pal_addr] <= pal_wdata;
  end

  assign fb_addr = fb_addr_q;
  assign fb_rd   = fb_rd_q;
  assign vga_r   = rgb_q[11:8];
  assign vga_g   = rgb_q[7:4];
  assign vga_b   = rgb_q[3:0];
  assign hsync   = hs_q;
  assign vsync   = vs_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch (RD_LATENCY=1).
// Colour and syncs are expected two strobes after the input sample.
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_strobe;
  logic        mode;
  logic        hsync_in;
  logic        vsync_in;
  logic        active_in;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [18:0] fb_addr;
  logic        fb_rd;
  logic [7:0]  fb_data;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [11:0] pal_wdata;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
`ifdef VGA_FETCH_TEST_PATTERN_EN
  logic        test_en;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_pixel_fetch #(.RD_LATENCY(1), .ADDR_W(19)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_strobe(pixel_strobe),
    .mode(mode), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .x(x), .y(y),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
`ifdef VGA_FETCH_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync)
  );

  // one strobe edge followed by one idle edge; starts and ends at negedge
  task automatic strobe();
    pixel_strobe = 1'b1;
    @(negedge clk);
    pixel_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic pal_write(input logic [7:0] a, input logic [11:0] d);
    pal_we = 1'b1; pal_addr = a; pal_wdata = d;
    @(negedge clk);
    pal_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pixel_strobe = 1'b0; mode = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
    x = '0; y = '0; fb_data = '0;
    pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
`ifdef VGA_FETCH_TEST_PATTERN_EN
    test_en = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++;
      $display("FAIL reset_rgb got=%h want=000", {vga_r, vga_g, vga_b}); end
    checks++; if (hsync !== 1'b1) begin errors++;
      $display("FAIL reset_hsync got=%b want=1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++;
      $display("FAIL reset_vsync got=%b want=1", vsync); end
    checks++; if (fb_rd !== 1'b0) begin errors++;
      $display("FAIL reset_fb_rd got=%b want=0", fb_rd); end
    checks++; if (fb_addr !== 19'd0) begin errors++;
      $display("FAIL reset_fb_addr got=%0d want=0", fb_addr); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addressing();
    mode = 1'b0; x = 10'd5; y = 9'd2; active_in = 1'b1;
    strobe();
    checks++; if (fb_addr !== 19'd1285) begin errors++;
      $display("FAIL addr_m0 got=%0d want=1285", fb_addr); end
    checks++; if (fb_rd !== 1'b1) begin errors++;
      $display("FAIL addr_rd got=%b want=1", fb_rd); end
    mode = 1'b1; x = 10'd319; y = 9'd239;
    strobe();
    checks++; if (fb_addr !== 19'd76799) begin errors++;
      $display("FAIL addr_m1_corner got=%0d want=76799", fb_addr); end
    mode = 1'b0; x = 10'd639; y = 9'd479;
    strobe();
    checks++; if (fb_addr !== 19'd307199) begin errors++;
      $display("FAIL addr_m0_corner got=%0d want=307199", fb_addr); end
    active_in = 1'b0; x = 10'd3; y = 9'd3;
    strobe();
    checks++; if (fb_addr !== 19'd307199) begin errors++;
      $display("FAIL addr_blank_hold got=%0d want=307199", fb_addr); end
    checks++; if (fb_rd !== 1'b0) begin errors++;
      $display("FAIL addr_blank_rd got=%b want=0", fb_rd); end
    strobe(); strobe();
  endtask

  task automatic test_latency();
    pal_write(8'h3C, 12'hF0A);
    mode = 1'b0; x = 10'd10; y = 9'd0; active_in = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; fb_data = 8'h00;
    strobe();
    checks++; if (fb_addr !== 19'd10) begin errors++;
      $display("FAIL lat_addr got=%0d want=10", fb_addr); end
    active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; fb_data = 8'h3C;
    strobe();
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h000 || hsync !== 1'b1) begin
      errors++;
      $display("FAIL lat_early got=%h/%b want=000/1",
               {vga_r, vga_g, vga_b}, hsync); end
    fb_data = 8'h00;
    strobe();
    checks++; if ({vga_r, vga_g, vga_b} !== 12'hF0A) begin errors++;
      $display("FAIL lat_rgb got=%h want=F0A", {vga_r, vga_g, vga_b}); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin errors++;
      $display("FAIL lat_sync got=%b%b want=00", hsync, vsync); end
    repeat (3) @(negedge clk);
    checks++; if ({vga_r, vga_g, vga_b} !== 12'hF0A) begin errors++;
      $display("FAIL lat_hold got=%h want=F0A", {vga_r, vga_g, vga_b}); end
    strobe();
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h000 || hsync !== 1'b1) begin
      errors++;
      $display("FAIL lat_after got=%h/%b want=000/1",
               {vga_r, vga_g, vga_b}, hsync); end
  endtask

  task automatic test_blanking();
    pal_write(8'hFF, 12'hFFF);
    active_in = 1'b0; fb_data = 8'hFF; x = 10'd100; y = 9'd100;
    for (int i = 0; i < 3; i++) begin
      strobe();
      checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++;
        $display("FAIL blank_rgb[%0d] got=%h want=000", i,
                 {vga_r, vga_g, vga_b}); end
    end
    checks++; if (fb_addr !== 19'd10 || fb_rd !== 1'b0) begin errors++;
      $display("FAIL blank_addr got=%0d/%b want=10/0", fb_addr, fb_rd); end
  endtask

  task automatic test_collision();
    pal_write(8'h07, 12'h000);
    active_in = 1'b1; x = 10'd0; y = 9'd0; fb_data = 8'h00;
    strobe();
    fb_data = 8'h07;
    strobe();
    active_in = 1'b0;
    pal_we = 1'b1; pal_addr = 8'h07; pal_wdata = 12'h123;
    strobe();
    pal_we = 1'b0;
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++;
      $display("FAIL coll_old got=%h want=000", {vga_r, vga_g, vga_b}); end
    fb_data = 8'h00;
    strobe();
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h123) begin errors++;
      $display("FAIL coll_new got=%h want=123", {vga_r, vga_g, vga_b}); end
    strobe();
  endtask

  task automatic test_reset_midframe();
    active_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; fb_data = 8'h07;
    repeat (3) strobe();
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h123 || hsync !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got=%h/%b want=123/0",
               {vga_r, vga_g, vga_b}, hsync); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h000 || hsync !== 1'b1 ||
                  vsync !== 1'b1 || fb_rd !== 1'b0) begin errors++;
      $display("FAIL mid_reset got=%h/%b%b/%b want=000/11/0",
               {vga_r, vga_g, vga_b}, hsync, vsync, fb_rd); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    strobe();
    strobe();
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h000 || hsync !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart_early got=%h/%b want=000/1",
               {vga_r, vga_g, vga_b}, hsync); end
    strobe();
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h123 || hsync !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart got=%h/%b want=123/0",
               {vga_r, vga_g, vga_b}, hsync); end
    active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) strobe();
  endtask

`ifdef VGA_FETCH_TEST_PATTERN_EN
  task automatic test_pattern();
    test_en = 1'b1; active_in = 1'b1; x = 10'd384; y = 9'd0;
    strobe();
    checks++; if (fb_rd !== 1'b0) begin errors++;
      $display("FAIL tp_rd got=%b want=0", fb_rd); end
    strobe(); strobe();
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h0FF) begin errors++;
      $display("FAIL tp_bar3 got=%h want=0FF", {vga_r, vga_g, vga_b}); end
    active_in = 1'b0;
    repeat (3) strobe();
    test_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_addressing();
    test_latency();
    test_blanking();
    test_collision();
    test_reset_midframe();
`ifdef VGA_FETCH_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
